// File: rtl/rng_pkg.sv
// Shared definitions for the random-number scheduler: LFSR geometry, tap
// positions, default seed, drawn-value width and the single-step function.
package rng_pkg;

  localparam int LFSR_W = 16;
  localparam int CAND_W = 3;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h600D;

  localparam int TAP_A = 0;
  localparam int TAP_B = 2;
  localparam int TAP_C = 3;
  localparam int TAP_D = 5;

  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic [CAND_W-1:0] cand_t;

  // Fibonacci step: feedback enters at the MSB, the register shifts right.
  function automatic lfsr_t lfsr_next(input lfsr_t s);
    return {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reset to SEED, a parallel load and
// a step enable. Load takes priority over step.
module lfsr16
  import rng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/rng_sched.sv
// Random-number scheduler: an LFSR feeds a 2-entry prefetch buffer of
// accepted values, handed out to requesters through a round-robin arbiter.
module rng_sched
  import rng_pkg::*;
#(
  parameter int                NREQ  = 4,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
  parameter int                RANGE = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  output logic [NREQ-1:0]   gnt,
  output logic [CAND_W-1:0] data,
  output logic [1:0]        level
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] load_val;
  logic              lockup;
  logic              lfsr_load;
  logic              step;
  logic              push;
  logic              pop;
  logic              grant_ok;
  logic [CAND_W-1:0] cand;
  logic [CAND_W-1:0] head;
  logic [CAND_W-1:0] tail;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  pick;
  logic [PTR_W-1:0]  ptr_next;

  function automatic logic [PTR_W-1:0] wrap(input int i);
    return PTR_W'(i % NREQ);
  endfunction

  // A zero state would stick forever, so it is treated as a reload request.
  assign lockup    = (state == '0);
  assign lfsr_load = seed_load || lockup;
  assign load_val  = (seed_load && (seed_val != '0)) ? seed_val : SEED;
  assign cand      = state[CAND_W-1:0];

  // Draw order is fixed by the LFSR alone: the register only moves when the
  // value it exposes has somewhere to go (or is being thrown away).
  assign step = !((level == 2'd2) && !pop);
  assign push = step && !lfsr_load && (int'(cand) < RANGE);

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .load    (lfsr_load),
    .load_val(load_val),
    .state   (state)
  );

  // Round-robin pick: walk downward so the lowest offset from ptr wins.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path leaves it holding its old value (which would infer a latch).
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        pick = wrap(int'(ptr) + k);
      end
    end
  end

  assign grant_ok = !reset && !seed_load && (level != 2'd0) && (|req);
  assign pop      = grant_ok;
  assign ptr_next = (pick == PTR_W'(NREQ - 1)) ? '0 : pick + PTR_W'(1);

  always_comb begin
    gnt = '0;
    if (grant_ok) begin
      gnt[pick] = 1'b1;
    end
  end

  assign data = grant_ok ? head : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two buffer slots are reset along with level; they are only
      // a handful of flops and keeping them defined avoids X on the datapath.
      level <= 2'd0;
      head  <= '0;
      tail  <= '0;
      ptr   <= '0;
    end else if (seed_load) begin
      level <= 2'd0;
    end else begin
      if (pop) begin
        ptr <= ptr_next;
      end
      case ({push, pop})
        2'b10: begin
          if (level == 2'd0) begin
            head <= cand;
          end else begin
            tail <= cand;
          end
          level <= level + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          level <= level - 2'd1;
        end
        2'b11: begin
          if (level == 2'd1) begin
            head <= cand;
          end else begin
            head <= tail;
            tail <= cand;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_sched.sv
// Bench for rng_sched: directed scenarios plus a randomized run against a
// queue-based reference model of the draw stream and round-robin order.
module tb_rng_sched;

  localparam int          NREQ  = 4;
  localparam int          RANGE = 7;
  localparam logic [15:0] SEED  = 16'h600D;

  logic            clk;
  logic            reset;
  logic            seed_load;
  logic [15:0]     seed_val;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [2:0]      data;
  logic [1:0]      level;

  int checks = 0;
  int errors = 0;

  rng_sched #(
    .NREQ (NREQ),
    .SEED (SEED),
    .RANGE(RANGE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .seed_load(seed_load),
    .seed_val (seed_val),
    .gnt      (gnt),
    .data     (data),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: LFSR value, queue of accepted draws, next-priority index.
  logic [15:0]     m_lfsr = SEED;
  logic [2:0]      m_q[$];
  int              m_ptr  = 0;
  int              m_gidx = -1;
  logic [NREQ-1:0] m_gnt;
  logic [2:0]      m_data;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic void model_comb();
    m_gnt  = '0;
    m_data = '0;
    m_gidx = -1;
    if (!reset && !seed_load && m_q.size() > 0 && req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_ptr + k) % NREQ;
        if (req[i] && m_gidx < 0) m_gidx = i;
      end
      m_gnt[m_gidx] = 1'b1;
      m_data        = m_q[0];
    end
  endfunction

  function automatic void model_seq();
    model_comb();
    if (reset) begin
      m_lfsr = SEED;
      m_q.delete();
      m_ptr = 0;
    end else if (seed_load) begin
      m_lfsr = (seed_val == 16'h0) ? SEED : seed_val;
      m_q.delete();
    end else begin
      if (m_gidx >= 0) begin
        m_q.delete(0);
        m_ptr = (m_gidx + 1) % NREQ;
      end
      if (m_lfsr == 16'h0) begin
        m_lfsr = SEED;
      end else if (m_q.size() < 2) begin
        if (int'(m_lfsr[2:0]) < RANGE) m_q.push_back(m_lfsr[2:0]);
        m_lfsr = lfsr_adv(m_lfsr);
      end
    end
  endfunction

  // Advance one clock; inputs are held from negedge to negedge.
  task automatic clock();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
    model_comb();
  endtask

  task automatic test_reset();
    reset = 1'b1; seed_load = 1'b0; seed_val = '0; req = '0;
    clock();
    clock();
    #2;
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++;
    if (data !== 3'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
    checks++;
    if (dut.u_lfsr.state !== SEED) begin
      errors++; $display("FAIL reset_lfsr: got %h want %h", dut.u_lfsr.state, SEED);
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [1:0] exp_level [3] = '{2'd1, 2'd2, 2'd2};
    req = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (gnt !== '0) begin errors++; $display("FAIL fill_gnt[%0d]: got %b want 0000", c, gnt); end
      clock();
      #2;
      checks++;
      if (level !== exp_level[c]) begin
        errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", c, level, exp_level[c]);
      end
    end
    checks++;
    if (dut.u_lfsr.state !== 16'hD803) begin
      errors++; $display("FAIL fill_lfsr_hold: got %h want d803", dut.u_lfsr.state);
    end
  endtask

  task automatic test_draw();
    logic [2:0] exp_data [4] = '{3'd5, 3'd6, 3'd3, 3'd1};
    @(negedge clk);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL draw_gnt[%0d]: got %b want 0001", c, gnt); end
      checks++;
      if (data !== exp_data[c]) begin
        errors++; $display("FAIL draw_data[%0d]: got %0d want %0d", c, data, exp_data[c]);
      end
      clock();
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int n = 0;
    reset = 1'b1;
    clock();
    reset = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 40 && n < 8; c++) begin
      settle();
      if (gnt !== '0) begin
        checks++;
        if (gnt !== NREQ'(1 << (n % NREQ))) begin
          errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, NREQ'(1 << (n % NREQ)));
        end
        n++;
      end
      clock();
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL rr_timeout: got %0d grants want 8", n); end
    req = '0;
  endtask

  task automatic test_back_to_back_reject();
    seed_load = 1'b1; seed_val = 16'h0007; req = '0;
    clock();
    seed_load = 1'b0;
    settle();
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL reject_level_pre: got %0d want 0", level); end
    clock();
    #2;
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL reject_level: got %0d want 0", level); end
    checks++;
    if (dut.u_lfsr.state !== 16'h0003) begin
      errors++; $display("FAIL reject_lfsr_step: got %h want 0003", dut.u_lfsr.state);
    end
    clock();
    req = 4'b0010;
    settle();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL reject_gnt: got %b want 0010", gnt); end
    checks++;
    if (data !== 3'd3) begin errors++; $display("FAIL reject_data: got %0d want 3", data); end
    clock();
    req = '0;
  endtask

  task automatic test_seed_zero();
    req = '0;
    for (int c = 0; c < 20 && level != 2'd2; c++) clock();
    checks++;
    if (level !== 2'd2) begin errors++; $display("FAIL seed0_fill: got %0d want 2", level); end
    seed_load = 1'b1; seed_val = 16'h0000; req = 4'b0010;
    settle();
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL seed0_gnt_load: got %b want 0000", gnt); end
    clock();
    seed_load = 1'b0;
    settle();
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL seed0_level: got %0d want 0", level); end
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL seed0_gnt_empty: got %b want 0000", gnt); end
    clock();
    settle();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL seed0_gnt: got %b want 0010", gnt); end
    checks++;
    if (data !== 3'd5) begin errors++; $display("FAIL seed0_data: got %0d want 5", data); end
    clock();
    req = '0;
  endtask

  task automatic test_reset_seed();
    req = '0;
    clock();
    clock();
    reset = 1'b1; seed_load = 1'b1; seed_val = 16'h1234; req = 4'b0001;
    settle();
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL rs_gnt_cycle: got %b want 0000", gnt); end
    clock();
    reset = 1'b0; seed_load = 1'b0;
    settle();
    checks++;
    if (level !== 2'd0) begin errors++; $display("FAIL rs_level: got %0d want 0", level); end
    checks++;
    if (gnt !== '0 || data !== 3'd0) begin
      errors++; $display("FAIL rs_idle: got gnt %b data %0d want 0000 0", gnt, data);
    end
    clock();
    settle();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rs_first_gnt: got %b want 0001", gnt); end
    checks++;
    if (data !== 3'd5) begin errors++; $display("FAIL rs_first_data: got %0d want 5", data); end
    clock();
    req = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pending = '0;
    logic [NREQ-1:0] granted;
    for (int c = 0; c < 500; c++) begin
      reset     = ($urandom_range(0, 49) == 0);
      seed_load = ($urandom_range(0, 24) == 0);
      seed_val  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 2) == 0) pending = pending | NREQ'($urandom);
      req = pending;
      settle();
      checks++;
      if (gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, m_gnt); end
      checks++;
      if (data !== m_data) begin errors++; $display("FAIL rand_data[%0d]: got %0d want %0d", c, data, m_data); end
      checks++;
      if (level !== 2'(m_q.size())) begin
        errors++; $display("FAIL rand_level[%0d]: got %0d want %0d", c, level, m_q.size());
      end
      granted = m_gnt;
      clock();
      pending = pending & ~granted;
    end
    reset = 1'b0; seed_load = 1'b0; req = '0;
  endtask

  initial begin
    reset = 1'b1; seed_load = 1'b0; seed_val = '0; req = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_draw();
    test_round_robin();
    test_back_to_back_reject();
    test_seed_zero();
    test_reset_seed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
